// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: runs WIDTH-bit operations through one 4-bit ALU slice,
// one nibble per clock, carrying the slice carries from one nibble to the next.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; the slice sees zero operands
// S_RUN  | one nibble per cycle, idx = 0..NIBBLES-1
// S_DONE | one-cycle done pulse; result and flags valid
module xalu_nibble_seq #(
    parameter int NIBBLES = 4,
    localparam int WIDTH = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             com,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic [2:0]       slice_f,
    output logic             slice_com,
    output logic             slice_ci_left,
    output logic             slice_ci_right,
    input  logic [3:0]       slice_d,
    input  logic             slice_co_left,
    input  logic             slice_co_right,
    input  logic             slice_equ
);

    localparam int IW = $clog2(NIBBLES);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             com_q;
    logic             carry_q;
    logic             equ_acc_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             zero_q;
    logic             neg_zero_q;
    logic             equ_q;

    logic [IW-1:0]    phys;
    logic             last_step;
    logic             right_chain;
    logic             left_chain;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [WIDTH-1:0] result_nxt;
    logic             carry_nxt;
    logic             equ_acc_nxt;

    // ADD and SHL ripple toward the MSB, SHR ripples toward the LSB.
    assign right_chain = (op_q == OP_ADD) || (op_q == OP_SHL);
    assign left_chain  = (op_q == OP_SHR);
    assign last_step   = (idx_q == IW'(NIBBLES - 1));

    // Map the step index onto a physical nibble, pick its operands and merge the slice output into the result.
    always_comb begin
        phys       = left_chain ? (IW'(NIBBLES - 1) - idx_q) : idx_q;
        nib_a      = '0;
        nib_b      = '0;
        result_nxt = result_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (phys == IW'(i)) begin
                nib_a                 = a_q[4*i +: 4];
                nib_b                 = b_q[4*i +: 4];
                result_nxt[4*i +: 4] = slice_d;
            end
        end
    end

    // Carry and equality values to be stored at the end of the current nibble step.
    always_comb begin
        carry_nxt   = carry_q;
        equ_acc_nxt = equ_acc_q & slice_equ;
        if (right_chain) begin
            carry_nxt = slice_co_left;
        end else if (left_chain) begin
            carry_nxt = slice_co_right;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic, handshake outputs and the slice drive.
    always_comb begin
        state_nxt      = state_q;
        busy           = 1'b0;
        done           = 1'b0;
        slice_a        = 4'd0;
        slice_b        = 4'd0;
        slice_ci_left  = 1'b0;
        slice_ci_right = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                slice_a = nib_a;
                slice_b = nib_b;
                if (right_chain) begin
                    slice_ci_right = carry_q;
                end
                if (left_chain) begin
                    slice_ci_left = carry_q;
                end
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, per-nibble capture and final flag evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            com_q       <= 1'b0;
            carry_q     <= 1'b0;
            equ_acc_q   <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            neg_zero_q  <= 1'b0;
            equ_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        op_q        <= op;
                        com_q       <= com;
                        carry_q     <= cin;
                        idx_q       <= '0;
                        equ_acc_q   <= 1'b1;
                        result_q    <= '0;
                        carry_out_q <= 1'b0;
                        zero_q      <= 1'b0;
                        neg_zero_q  <= 1'b0;
                        equ_q       <= 1'b0;
                    end
                end
                S_RUN: begin
                    result_q  <= result_nxt;
                    carry_q   <= carry_nxt;
                    equ_acc_q <= equ_acc_nxt;
                    if (last_step) begin
                        // Flags must be valid in the done cycle, so they are taken from the merged next result.
                        idx_q       <= '0;
                        carry_out_q <= (right_chain || left_chain) ? carry_nxt : 1'b0;
                        zero_q      <= (result_nxt == '0);
                        neg_zero_q  <= &result_nxt;
                        equ_q       <= equ_acc_nxt;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign slice_f   = op_q;
    assign slice_com = com_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;
    assign neg_zero  = neg_zero_q;
    assign equ       = equ_q;

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// tb_xalu_nibble_seq: drives xalu_nibble_seq with a behavioural 4-bit slice
// and checks full-width results against a whole-word reference model.
module tb_xalu_nibble_seq;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic         com;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         neg_zero;
    logic         equ;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic [2:0]   slice_f;
    logic         slice_com;
    logic         slice_ci_left;
    logic         slice_ci_right;
    logic [3:0]   slice_d;
    logic         slice_co_left;
    logic         slice_co_right;
    logic         slice_equ;

    int n_chk = 0;
    int n_err = 0;

    xalu_nibble_seq #(.NIBBLES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op             (op),
        .com            (com),
        .cin            (cin),
        .a              (a),
        .b              (b),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .carry_out      (carry_out),
        .zero           (zero),
        .neg_zero       (neg_zero),
        .equ            (equ),
        .slice_a        (slice_a),
        .slice_b        (slice_b),
        .slice_f        (slice_f),
        .slice_com      (slice_com),
        .slice_ci_left  (slice_ci_left),
        .slice_ci_right (slice_ci_right),
        .slice_d        (slice_d),
        .slice_co_left  (slice_co_left),
        .slice_co_right (slice_co_right),
        .slice_equ      (slice_equ)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit ALU slice.
    logic [3:0] s_raw;
    logic [4:0] s_sum;
    always_comb begin
        s_raw          = 4'd0;
        s_sum          = 5'd0;
        slice_co_left  = 1'b0;
        slice_co_right = 1'b0;
        case (slice_f)
            3'd0: begin
                s_sum         = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_ci_right};
                s_raw         = s_sum[3:0];
                slice_co_left = s_sum[4];
            end
            3'd1: s_raw = slice_a & slice_b;
            3'd2: s_raw = slice_a | slice_b;
            3'd3: s_raw = slice_a ^ slice_b;
            3'd4: s_raw = slice_a;
            3'd5: s_raw = slice_b;
            3'd6: begin
                s_raw          = {slice_ci_left, slice_a[3:1]};
                slice_co_right = slice_a[0];
            end
            default: begin
                s_raw         = {slice_a[2:0], slice_ci_right};
                slice_co_left = slice_a[3];
            end
        endcase
        slice_d   = slice_com ? ~s_raw : s_raw;
        slice_equ = (slice_a == slice_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference of the operation.
    function automatic void ref_op(input logic [2:0] f, input logic c, input logic ci,
                                   input logic [W-1:0] av, input logic [W-1:0] bv,
                                   output logic [W-1:0] r, output logic co);
        logic [W:0] t;
        r  = '0;
        co = 1'b0;
        case (f)
            3'd0: begin
                t  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
                r  = t[W-1:0];
                co = t[W];
            end
            3'd1: r = av & bv;
            3'd2: r = av | bv;
            3'd3: r = av ^ bv;
            3'd4: r = av;
            3'd5: r = bv;
            3'd6: begin
                r  = {ci, av[W-1:1]};
                co = av[0];
            end
            default: begin
                r  = {av[W-2:0], ci};
                co = av[W-1];
            end
        endcase
        if (c) r = ~r;
    endfunction

    // Carry that must enter the slice at step k.
    function automatic logic exp_carry_in(input logic [2:0] f, input logic ci,
                                          input logic [W-1:0] av, input logic [W-1:0] bv, input int k);
        logic [31:0] mask;
        logic [31:0] s;
        if (k == 0) return ci;
        case (f)
            3'd0: begin
                mask = (32'd1 << (4 * k)) - 32'd1;
                s    = ({16'd0, av} & mask) + ({16'd0, bv} & mask) + {31'd0, ci};
                return s[4 * k];
            end
            3'd6:    return av[4 * (N - k)];
            3'd7:    return av[4 * k - 1];
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic c, input logic ci,
                         input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke);
        logic [W-1:0] er;
        logic         ec;
        logic         ecar;
        int           p;
        ref_op(f, c, ci, av, bv, er, ec);
        @(negedge clk);
        op = f; com = c; cin = ci; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            p    = (f == 3'd6) ? (N - 1 - k) : k;
            ecar = exp_carry_in(f, ci, av, bv, k);
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("done_run", {31'd0, done}, 32'd0);
            chk("slice_a", {28'd0, slice_a}, {28'd0, av[4*p +: 4]});
            chk("slice_b", {28'd0, slice_b}, {28'd0, bv[4*p +: 4]});
            chk("slice_f", {29'd0, slice_f}, {29'd0, f});
            chk("slice_ci_right", {31'd0, slice_ci_right},
                {31'd0, ((f == 3'd0) || (f == 3'd7)) ? ecar : 1'b0});
            chk("slice_ci_left", {31'd0, slice_ci_left}, {31'd0, (f == 3'd6) ? ecar : 1'b0});
            if (poke && k == 1) begin
                start = 1'b1; a = ~av; op = f ^ 3'd1;
            end
            @(negedge clk);
            start = 1'b0; a = av; op = f;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("result", {16'd0, result}, {16'd0, er});
        chk("carry_out", {31'd0, carry_out}, {31'd0, ec});
        chk("zero", {31'd0, zero}, {31'd0, er == 16'd0});
        chk("neg_zero", {31'd0, neg_zero}, {31'd0, er == 16'hFFFF});
        chk("equ", {31'd0, equ}, {31'd0, av == bv});
        @(negedge clk);
        chk("done_after", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("result_held", {16'd0, result}, {16'd0, er});
        chk("slice_a_idle", {28'd0, slice_a}, 32'd0);
        chk("slice_f_idle", {29'd0, slice_f}, {29'd0, f});
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_result"}, {16'd0, result}, 32'd0);
        chk({tag, "_carry_out"}, {31'd0, carry_out}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
        chk({tag, "_neg_zero"}, {31'd0, neg_zero}, 32'd0);
        chk({tag, "_equ"}, {31'd0, equ}, 32'd0);
        chk({tag, "_slice_a"}, {28'd0, slice_a}, 32'd0);
        chk({tag, "_ci_right"}, {31'd0, slice_ci_right}, 32'd0);
    endtask

    initial begin
        logic [2:0]   rf;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        do_op(3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
        do_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        do_op(3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, 1'b0);
        do_op(3'd7, 1'b0, 1'b0, 16'h8421, 16'h0000, 1'b0);
        do_op(3'd3, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0);
        do_op(3'd3, 1'b1, 1'b0, 16'h5A5A, 16'h5A5B, 1'b0);
        do_op(3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b1);

        // Reset in RUN step 2 aborts the operation without a done pulse.
        @(negedge clk);
        op = 3'd0; com = 1'b0; cin = 1'b1; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_cleared("midrun_rst");
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        do_op(3'd0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);

        for (int i = 0; i < 80; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ~ra - 16'($urandom_range(0, 1)) + 16'd1;
            do_op(rf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb,
                  ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
